// File: rtl/nine_s_complementer.sv
// ---------------------------------------------------------------------------
// nine_s_complementer
//
// Takes one BCD digit, forms its nine's complement (9 - x) and drives a single
// digit of a 4-digit common-anode 7-segment display with the result. All
// outputs come straight from flops, so there is no combinational path from x
// to the display pins. Out-of-range inputs (10..15) show a dash.
//
// Parameters
//   SEG_ACTIVE_LOW : 1 -> a segment is lit when its bit is 0 (common anode)
//                    0 -> segment polarity inverted (lit = 1)
//   DIGIT_SEL      : index 0..3 of the anode that is enabled (0 = an[0])
//
// Ports
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-high reset
//   x      in   4      BCD input digit (0..9 valid)
//   seg    out  [0:6]  segments, seg[0] = a ... seg[6] = g
//   an     out  4      anode enables, active-low
//   dp     out  1      decimal point, active-low, held off (1)
// ---------------------------------------------------------------------------
module nine_s_complementer #(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned DIGIT_SEL      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] x,
    output logic [0:6] seg,
    output logic [3:0] an,
    output logic       dp
);

    // Segment word with every segment dark, in the selected polarity.
    localparam logic [0:6] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    // Anode word with only the chosen digit enabled (active-low).
    localparam logic [3:0] AN_ON = ~(4'b0001 << DIGIT_SEL);

    // Active-low a..g pattern for a decimal digit; anything above 9 is a dash.
    function automatic logic [0:6] decode_al(input logic [3:0] digit);
        logic [0:6] pat;
        case (digit)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = 7'b1111110;
        endcase
        return pat;
    endfunction

    logic [3:0] comp_s;
    logic [0:6] pat_al_s;
    logic [0:6] seg_d, seg_q;
    logic [3:0] an_d,  an_q;
    logic       dp_d,  dp_q;

    // Complement and decode the incoming digit into the next segment word.
    always_comb begin
        comp_s   = 4'd15;
        pat_al_s = 7'b1111110;
        seg_d    = SEG_OFF;
        an_d     = AN_ON;
        dp_d     = 1'b1;

        // Invalid codes are steered to 15 so the decoder's dash branch fires.
        if (x <= 4'd9) begin
            comp_s = 4'd9 - x;
        end else begin
            comp_s = 4'd15;
        end

        pat_al_s = decode_al(comp_s);

        if (SEG_ACTIVE_LOW) begin
            seg_d = pat_al_s;
        end else begin
            seg_d = ~pat_al_s;
        end
    end

    // Output registers; reset blanks the display without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= 4'b1111;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_nine_s_complementer.sv
// ---------------------------------------------------------------------------
// tb_nine_s_complementer
//
// Directed bench for nine_s_complementer. Two instances share clock and
// reset: u_dut uses the default parameters, u_alt uses inverted segment
// polarity and DIGIT_SEL = 2. Inputs change and outputs are sampled on the
// falling clock edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_nine_s_complementer;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic [3:0] x;
    logic [3:0] x2;
    logic [0:6] seg;
    logic [3:0] an;
    logic       dp;
    logic [0:6] seg2;
    logic [3:0] an2;
    logic       dp2;

    int pass_cnt;
    int chk_cnt;

    // Hand-computed active-low patterns for input x = 0..9 (showing 9 - x).
    logic [6:0] exp_sweep [10];

    nine_s_complementer u_dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    nine_s_complementer #(
        .SEG_ACTIVE_LOW (1'b0),
        .DIGIT_SEL      (2)
    ) u_alt (
        .clk   (clk),
        .reset (reset),
        .x     (x2),
        .seg   (seg2),
        .an    (an2),
        .dp    (dp2)
    );

    // Clock runs only once enabled, so the first reset checks see no edge.
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        reset    = 1'b0;
        x        = 4'd5;
        x2       = 4'd1;

        exp_sweep[0] = 7'b0000100;
        exp_sweep[1] = 7'b0000000;
        exp_sweep[2] = 7'b0001111;
        exp_sweep[3] = 7'b0100000;
        exp_sweep[4] = 7'b0100100;
        exp_sweep[5] = 7'b1001100;
        exp_sweep[6] = 7'b0000110;
        exp_sweep[7] = 7'b0010010;
        exp_sweep[8] = 7'b1001111;
        exp_sweep[9] = 7'b0000001;

        // Reset asserted with no clock running: outputs must blank at once.
        #1 reset = 1'b1;
        #1;
        check("rst_noclk_seg", seg, 7'b1111111);
        check("rst_noclk_an",  {3'b000, an}, {3'b000, 4'b1111});
        check("rst_noclk_dp",  {6'b000000, dp}, {6'b000000, 1'b1});
        check("rst_noclk_alt_seg", seg2, 7'b0000000);

        // Clocks running while reset held: still blank.
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_held_seg", seg, 7'b1111111);
        check("rst_held_an",  {3'b000, an}, {3'b000, 4'b1111});

        // Release reset with x = 0; one edge later the display shows 9.
        x     = 4'd0;
        reset = 1'b0;
        #1;
        check("pre_edge_seg", seg, 7'b1111111);
        @(negedge clk);
        check("first_seg", seg, 7'b0000100);
        check("first_an",  {3'b000, an}, {3'b000, 4'b1110});
        check("first_dp",  {6'b000000, dp}, {6'b000000, 1'b1});
        check("alt_x1_seg", seg2, 7'b1111111);
        check("alt_x1_an",  {3'b000, an2}, {3'b000, 4'b1011});
        check("alt_dp",     {6'b000000, dp2}, {6'b000000, 1'b1});

        // Sweep 0..9; output must hold the old value until the next edge.
        for (int i = 0; i < 10; i++) begin
            x = 4'(i);
            #1;
            if (i > 0) check("hold_before_edge", seg, exp_sweep[i-1]);
            @(negedge clk);
            check($sformatf("sweep_x%0d", i), seg, exp_sweep[i]);
        end
        check("sweep_an", {3'b000, an}, {3'b000, 4'b1110});

        // Invalid inputs show a dash.
        x = 4'd10;
        @(negedge clk);
        check("dash_x10", seg, 7'b1111110);
        x = 4'd15;
        @(negedge clk);
        check("dash_x15", seg, 7'b1111110);
        check("dash_an",  {3'b000, an}, {3'b000, 4'b1110});
        check("dash_dp",  {6'b000000, dp}, {6'b000000, 1'b1});

        // Alternate instance: inverted polarity.
        x2 = 4'd9;
        @(negedge clk);
        check("alt_x9_seg", seg2, 7'b1111110);
        x2 = 4'd12;
        @(negedge clk);
        check("alt_dash_seg", seg2, 7'b0000001);

        // Mid-sweep reset: x = 4 shown, then async reset between edges.
        x = 4'd4;
        @(negedge clk);
        check("mid_x4_seg", seg, 7'b0100100);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_seg", seg, 7'b1111111);
        check("mid_rst_an",  {3'b000, an}, {3'b000, 4'b1111});
        check("mid_rst_dp",  {6'b000000, dp}, {6'b000000, 1'b1});
        check("mid_rst_alt_seg", seg2, 7'b0000000);
        check("mid_rst_alt_an",  {3'b000, an2}, {3'b000, 4'b1111});
        @(negedge clk);
        check("mid_rst_held_seg", seg, 7'b1111111);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_seg", seg, 7'b0100100);
        check("post_rst_an",  {3'b000, an}, {3'b000, 4'b1110});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
